// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the multi-cycle right-shift sequencer.
// The optional sticky-bit output is enabled by defining SHIFT_STICKY_EN.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 128;
  localparam int DEF_STEP  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Shift-amount width needed to express 0..width-1.
  function automatic int amt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_seq_step.sv
// Combinational right shift by k (0..STEP) with a selectable fill bit.
// With SHIFT_STICKY_EN defined, also reports the OR of the bits dropped.
module shift_seq_step
  import shift_seq_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  STEP  = DEF_STEP,
  localparam int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  logic             fill,
  output logic [WIDTH-1:0] result
`ifdef SHIFT_STICKY_EN
  ,
  output logic             dropped
`endif
);

  logic [WIDTH+STEP-1:0] ext;

  assign ext = {{STEP{fill}}, data};

  // Each result bit picks from a STEP+1 wide window starting at its own position.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [STEP:0] win;
      assign win        = ext[gi +: STEP + 1];
      assign result[gi] = win[k];
    end
  endgenerate

`ifdef SHIFT_STICKY_EN
  logic [STEP-1:0] low_mask;

  generate
    for (gi = 0; gi < STEP; gi++) begin : g_mask
      assign low_mask[gi] = (k > KW'(gi));
    end
  endgenerate

  assign dropped = |(data[STEP-1:0] & low_mask);
`endif

endmodule

// File: rtl/arith_shift_sequencer.sv
// Multi-cycle arithmetic/logical right-shift engine with valid/ready on both sides.
// Define SHIFT_STICKY_EN to add out_sticky (OR of all bits shifted out).
module arith_shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  STEP  = DEF_STEP,
  localparam int AMT_W = amt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFT_STICKY_EN
  ,
  output logic             out_sticky
`endif
);

  localparam int KW = $clog2(STEP + 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [AMT_W-1:0] rem_reg, rem_next;
  logic             arith_reg, arith_next;
  logic [WIDTH-1:0] step_result;
  logic [KW-1:0]    step_k;
  logic             step_fill;

`ifdef SHIFT_STICKY_EN
  logic sticky_reg, sticky_next;
  logic step_dropped;
`endif

  // The MSB is invariant under arithmetic shifting, so it always equals the original sign.
  assign step_fill = arith_reg & data_reg[WIDTH-1];
  assign step_k    = (rem_reg < AMT_W'(STEP)) ? rem_reg[KW-1:0] : KW'(STEP);

  shift_seq_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data    (data_reg),
    .k       (step_k),
    .fill    (step_fill),
    .result  (step_result)
`ifdef SHIFT_STICKY_EN
    ,
    .dropped (step_dropped)
`endif
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_reg   <= '0;
      rem_reg    <= '0;
      arith_reg  <= 1'b0;
`ifdef SHIFT_STICKY_EN
      sticky_reg <= 1'b0;
`endif
    end else begin
      data_reg   <= data_next;
      rem_reg    <= rem_next;
      arith_reg  <= arith_next;
`ifdef SHIFT_STICKY_EN
      sticky_reg <= sticky_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    rem_next    = rem_reg;
    arith_next  = arith_reg;
`ifdef SHIFT_STICKY_EN
    sticky_next = sticky_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          data_next   = in_data;
          rem_next    = in_amount;
          arith_next  = in_arith;
`ifdef SHIFT_STICKY_EN
          sticky_next = 1'b0;
`endif
          state_next  = (in_amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_next   = step_result;
        rem_next    = rem_reg - AMT_W'(step_k);
`ifdef SHIFT_STICKY_EN
        sticky_next = sticky_reg | step_dropped;
`endif
        if (rem_reg <= AMT_W'(STEP)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE here leaves a one-cycle bubble before the next accept.
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign out_data   = data_reg;
`ifdef SHIFT_STICKY_EN
  assign out_sticky = sticky_reg;
`endif

endmodule

// File: tb/tb_arith_shift_sequencer.sv
// Directed self-checking bench for arith_shift_sequencer (STEP=1 and STEP=4 instances).
// Sticky checks are included when SHIFT_STICKY_EN is defined.
module tb_arith_shift_sequencer;

  logic         clock;
  logic         reset;
  logic [127:0] in_data;
  logic [6:0]   in_amount;
  logic         in_arith;

  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [127:0] out_data_a;
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [127:0] out_data_b;
`ifdef SHIFT_STICKY_EN
  logic         out_sticky_a, out_sticky_b;
`endif

  int           tests_run;
  int           tests_failed;
  logic [127:0] res_data;
  int           res_lat;
  logic         res_sticky;

  arith_shift_sequencer #(.WIDTH(128), .STEP(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid_a),
    .in_ready   (in_ready_a),
    .in_data    (in_data),
    .in_amount  (in_amount),
    .in_arith   (in_arith),
    .out_valid  (out_valid_a),
    .out_ready  (out_ready_a),
    .out_data   (out_data_a)
`ifdef SHIFT_STICKY_EN
    ,
    .out_sticky (out_sticky_a)
`endif
  );

  arith_shift_sequencer #(.WIDTH(128), .STEP(4)) dut4 (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .in_data    (in_data),
    .in_amount  (in_amount),
    .in_arith   (in_arith),
    .out_valid  (out_valid_b),
    .out_ready  (out_ready_b),
    .out_data   (out_data_b)
`ifdef SHIFT_STICKY_EN
    ,
    .out_sticky (out_sticky_b)
`endif
  );

  always #5 clock = ~clock;

  // Accepts one operation on the selected instance and waits (bounded) for out_valid.
  task automatic do_op(input bit sel, input logic [127:0] d, input logic [6:0] a, input logic ar);
    in_data   = d;
    in_amount = a;
    in_arith  = ar;
    if (sel) in_valid_b = 1'b1;
    else     in_valid_a = 1'b1;
    @(posedge clock);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    res_lat = 1;
    while (!(sel ? out_valid_b : out_valid_a) && res_lat < 400) begin
      @(posedge clock);
      #1;
      res_lat++;
    end
    res_data = sel ? out_data_b : out_data_a;
`ifdef SHIFT_STICKY_EN
    res_sticky = sel ? out_sticky_b : out_sticky_a;
`else
    res_sticky = 1'b0;
`endif
  endtask

  task automatic finish_op(input bit sel);
    if (sel) out_ready_b = 1'b1;
    else     out_ready_a = 1'b1;
    @(posedge clock);
    #1;
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid_a);
    end
    tests_run++;
    if (out_data_a !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_out_data: got %h expected 0", out_data_a);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    tests_run++;
    if (in_ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready_a);
    end
    $display("[TB] reset: out_valid=%b out_data=%h in_ready=%b", out_valid_a, out_data_a, in_ready_a);
  endtask

  task automatic test_arith();
    do_op(1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_00F0, 7'd4, 1'b1);
    tests_run++;
    if (res_data !== 128'hF800_0000_0000_0000_0000_0000_0000_000F) begin
      tests_failed++;
      $display("FAIL arith_data: got %h expected %h", res_data, 128'hF800_0000_0000_0000_0000_0000_0000_000F);
    end
    tests_run++;
    if (res_lat !== 5) begin
      tests_failed++;
      $display("FAIL arith_latency: got %0d expected 5", res_lat);
    end
`ifdef SHIFT_STICKY_EN
    tests_run++;
    if (res_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL arith_sticky: got %b expected 0", res_sticky);
    end
`endif
    $display("[TB] arith: data=%h lat=%0d sticky=%b", res_data, res_lat, res_sticky);
    finish_op(1'b0);
  endtask

  task automatic test_logical();
    do_op(1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_00F0, 7'd4, 1'b0);
    tests_run++;
    if (res_data !== 128'h0800_0000_0000_0000_0000_0000_0000_000F) begin
      tests_failed++;
      $display("FAIL logical_data: got %h expected %h", res_data, 128'h0800_0000_0000_0000_0000_0000_0000_000F);
    end
    tests_run++;
    if (res_lat !== 5) begin
      tests_failed++;
      $display("FAIL logical_latency: got %0d expected 5", res_lat);
    end
    $display("[TB] logical: data=%h lat=%0d", res_data, res_lat);
    finish_op(1'b0);
  endtask

  task automatic test_zero_amount();
    do_op(1'b0, 128'h1234, 7'd0, 1'b1);
    tests_run++;
    if (res_data !== 128'h1234) begin
      tests_failed++;
      $display("FAIL zero_data: got %h expected %h", res_data, 128'h1234);
    end
    tests_run++;
    if (res_lat !== 1) begin
      tests_failed++;
      $display("FAIL zero_latency: got %0d expected 1", res_lat);
    end
`ifdef SHIFT_STICKY_EN
    tests_run++;
    if (res_sticky !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_sticky: got %b expected 0", res_sticky);
    end
`endif
    $display("[TB] zero amount: data=%h lat=%0d", res_data, res_lat);
    finish_op(1'b0);
  endtask

  task automatic test_saturate();
    logic [127:0] ones;
    ones = '1;
    do_op(1'b0, {1'b1, 127'h0}, 7'd127, 1'b1);
    tests_run++;
    if (res_data !== ones) begin
      tests_failed++;
      $display("FAIL saturate_data: got %h expected %h", res_data, ones);
    end
    tests_run++;
    if (res_lat !== 128) begin
      tests_failed++;
      $display("FAIL saturate_latency: got %0d expected 128", res_lat);
    end
    $display("[TB] saturate: data=%h lat=%0d", res_data, res_lat);
    finish_op(1'b0);
  endtask

  task automatic test_backpressure();
    do_op(1'b0, 128'hF0, 7'd2, 1'b0);
    tests_run++;
    if (res_data !== 128'h3C) begin
      tests_failed++;
      $display("FAIL bp_data: got %h expected 3c", res_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      tests_run++;
      if (out_valid_a !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid_a);
      end
      tests_run++;
      if (out_data_a !== 128'h3C) begin
        tests_failed++;
        $display("FAIL bp_hold_data[%0d]: got %h expected 3c", i, out_data_a);
      end
      tests_run++;
      if (in_ready_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold_in_ready[%0d]: got %b expected 0", i, in_ready_a);
      end
      $display("[TB] backpressure hold %0d: valid=%b data=%h in_ready=%b", i, out_valid_a, out_data_a, in_ready_a);
    end
    // New operation offered in the same cycle the result is taken must not be accepted.
    in_data     = 128'h55;
    in_amount   = 7'd0;
    in_arith    = 1'b0;
    in_valid_a  = 1'b1;
    out_ready_a = 1'b1;
    @(posedge clock);
    #1;
    out_ready_a = 1'b0;
    tests_run++;
    if (out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release_valid: got %b expected 0", out_valid_a);
    end
    tests_run++;
    if (in_ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_bubble_in_ready: got %b expected 1", in_ready_a);
    end
    @(posedge clock);
    #1;
    in_valid_a = 1'b0;
    tests_run++;
    if (out_valid_a !== 1'b1 || out_data_a !== 128'h55) begin
      tests_failed++;
      $display("FAIL bp_next_op: got valid=%b data=%h expected valid=1 data=55", out_valid_a, out_data_a);
    end
    $display("[TB] back-to-back: valid=%b data=%h", out_valid_a, out_data_a);
    finish_op(1'b0);
  endtask

  task automatic test_reset_mid();
    in_data    = '1;
    in_amount  = 7'd100;
    in_arith   = 1'b0;
    in_valid_a = 1'b1;
    @(posedge clock);
    #1;
    in_valid_a = 1'b0;
    repeat (19) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_valid: got %b expected 0", out_valid_a);
    end
    tests_run++;
    if (out_data_a !== 128'h0) begin
      tests_failed++;
      $display("FAIL midreset_data: got %h expected 0", out_data_a);
    end
    $display("[TB] mid-shift reset: valid=%b data=%h", out_valid_a, out_data_a);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    do_op(1'b0, 128'h10, 7'd4, 1'b0);
    tests_run++;
    if (res_data !== 128'h1) begin
      tests_failed++;
      $display("FAIL midreset_after_data: got %h expected 1", res_data);
    end
    $display("[TB] after reset: data=%h lat=%0d", res_data, res_lat);
    finish_op(1'b0);
  endtask

  task automatic test_step4();
    do_op(1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0C00, 7'd10, 1'b1);
    tests_run++;
    if (res_data !== 128'hFFE0_0000_0000_0000_0000_0000_0000_0003) begin
      tests_failed++;
      $display("FAIL step4_data: got %h expected %h", res_data, 128'hFFE0_0000_0000_0000_0000_0000_0000_0003);
    end
    tests_run++;
    if (res_lat !== 4) begin
      tests_failed++;
      $display("FAIL step4_latency: got %0d expected 4", res_lat);
    end
    $display("[TB] step4: data=%h lat=%0d", res_data, res_lat);
    finish_op(1'b1);
    do_op(1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0C00, 7'd10, 1'b1);
    tests_run++;
    if (res_data !== 128'hFFE0_0000_0000_0000_0000_0000_0000_0003) begin
      tests_failed++;
      $display("FAIL step1_same_data: got %h expected %h", res_data, 128'hFFE0_0000_0000_0000_0000_0000_0000_0003);
    end
    tests_run++;
    if (res_lat !== 11) begin
      tests_failed++;
      $display("FAIL step1_latency: got %0d expected 11", res_lat);
    end
    $display("[TB] step1 same op: data=%h lat=%0d", res_data, res_lat);
    finish_op(1'b0);
  endtask

`ifdef SHIFT_STICKY_EN
  task automatic test_sticky();
    do_op(1'b0, 128'h1, 7'd1, 1'b0);
    tests_run++;
    if (res_data !== 128'h0) begin
      tests_failed++;
      $display("FAIL sticky_data: got %h expected 0", res_data);
    end
    tests_run++;
    if (res_sticky !== 1'b1) begin
      tests_failed++;
      $display("FAIL sticky_bit: got %b expected 1", res_sticky);
    end
    $display("[TB] sticky step1: data=%h sticky=%b", res_data, res_sticky);
    finish_op(1'b0);
    do_op(1'b1, 128'h200, 7'd10, 1'b0);
    tests_run++;
    if (res_data !== 128'h0 || res_sticky !== 1'b1) begin
      tests_failed++;
      $display("FAIL sticky_step4: got data=%h sticky=%b expected data=0 sticky=1", res_data, res_sticky);
    end
    $display("[TB] sticky step4: data=%h sticky=%b", res_data, res_sticky);
    finish_op(1'b1);
  endtask
`endif

  initial begin
    clock        = 1'b0;
    reset        = 1'b1;
    in_valid_a   = 1'b0;
    in_valid_b   = 1'b0;
    out_ready_a  = 1'b0;
    out_ready_b  = 1'b0;
    in_data      = '0;
    in_amount    = '0;
    in_arith     = 1'b0;
    tests_run    = 0;
    tests_failed = 0;
    res_data     = '0;
    res_lat      = 0;
    res_sticky   = 1'b0;

    test_reset();
    test_arith();
    test_logical();
    test_zero_amount();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    test_step4();
`ifdef SHIFT_STICKY_EN
    test_sticky();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
